cp0_unit: RTL and testbench

Coprocessor-0 block for the P7 exception-capable pipeline. It sits beside the M stage and is the consumer end of the exception path. Decode and later stages tag each instruction with a 5-bit exception code; this block accepts that code, together with the hardware interrupt lines. It arbitrates them, latches SR/Cause/EPC, raises the flush/redirect request, and serves mfc0/mtc0/eret.

---
 rtl/cp0_pkg.sv | 22 ++
 rtl/cp0_unit.sv | 105 ++++++++++
 tb/tb_cp0_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers, write masks,
// exception codes and default entry/identification values.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [31:0] SR_WMASK  = 32'h0000_FC03;
  localparam logic [31:0] EPC_WMASK = 32'hFFFF_FFFC;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT    = 32'h434F_5037;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: arbitrates interrupts against M-stage exceptions, holds
// SR/Cause/EPC, and serves mfc0/mtc0/eret for the pipeline.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = PRID_DEFAULT,
  parameter logic [31:0] HANDLER = HANDLER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] Handler_PC,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_p;
  logic        w_exc_p;
  logic [31:0] w_pc_al;
  logic [31:0] w_epc_entry;
  logic [31:0] w_din_sr;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_mtc0;

  assign w_int_p = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_p = (ExcCode_M != 5'd0) & ~r_exl;
  assign IntReq  = w_int_p | w_exc_p;

  // A faulting instruction never commits its own mtc0.
  assign w_mtc0 = WE & ~IntReq;

  assign w_pc_al     = PC_M & EPC_WMASK;
  assign w_epc_entry = BD_M ? (w_pc_al - 32'd4) : w_pc_al;
  assign w_din_sr    = DIn & SR_WMASK;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (IntReq) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_p ? EXC_INT : ExcCode_M;
        r_bd      <= BD_M;
        r_epc     <= w_epc_entry;
      end else if (w_mtc0) begin
        if (A2 == REG_SR) begin
          r_im  <= w_din_sr[15:10];
          r_exl <= w_din_sr[1];
          r_ie  <= w_din_sr[0];
        end
        if (A2 == REG_EPC) begin
          r_epc <= DIn & EPC_WMASK;
        end
      end
      // eret takes precedence over any same-cycle write of EXL.
      if (EXLClr) begin
        r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = w_sr;
      REG_CAUSE: DOut = w_cause;
      REG_EPC:   DOut = r_epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  // Bypass lets an eret directly behind an mtc0 EPC see the new target.
  assign EPC_out    = (WE && (A2 == REG_EPC)) ? (DIn & EPC_WMASK) : r_epc;
  assign Handler_PC = HANDLER;

endmodule

// File: tb/tb_cp0_unit.sv
// Randomised and directed bench for cp0_unit against a word-level model of
// the CP0 register rules.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V    = 32'h434F_5037;
  localparam logic [31:0] HANDLER_V = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  A1 = 5'd0;
  logic [4:0]  A2 = 5'd0;
  logic [31:0] DIn = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] PC_M = 32'd0;
  logic        BD_M = 1'b0;
  logic [4:0]  ExcCode_M = 5'd0;
  logic [5:0]  HWInt = 6'd0;
  logic        EXLClr = 1'b0;
  logic        IntReq;
  logic [31:0] Handler_PC;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state as architectural 32-bit register images.
  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC_M(PC_M), .BD_M(BD_M), .ExcCode_M(ExcCode_M), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntReq(IntReq), .Handler_PC(Handler_PC),
    .EPC_out(EPC_out), .DOut(DOut)
  );

  always #10 clk = ~clk;

  function automatic logic m_int_p();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_intreq();
    return m_int_p() || ((ExcCode_M != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    if (WE && A2 == 5'd14) return {DIn[31:2], 2'b00};
    return m_epc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
    A1 = a;
    #1;
    chk(name, DOut, exp);
  endtask

  task automatic m_reset();
    m_sr = 32'd0;
    m_cause = 32'd0;
    m_epc = 32'd0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic cyc();
    logic req;
    logic ip;
    logic [31:0] base;
    @(negedge clk);
    chk("IntReq", {31'd0, IntReq}, {31'd0, m_intreq()});
    chk("DOut", DOut, m_read(A1));
    chk("EPC_out", EPC_out, m_epc_out());
    chk("Handler_PC", Handler_PC, HANDLER_V);
    req = m_intreq();
    ip = m_int_p();
    @(posedge clk);
    if (reset) begin
      m_cause[15:10] = HWInt;
      if (req) begin
        base = {PC_M[31:2], 2'b00};
        m_sr[1] = 1'b1;
        m_cause[6:2] = ip ? 5'd0 : ExcCode_M;
        m_cause[31] = BD_M;
        m_epc = BD_M ? base - 32'd4 : base;
      end else if (WE) begin
        if (A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
        if (A2 == 5'd14) m_epc = {DIn[31:2], 2'b00};
      end
      if (EXLClr) m_sr[1] = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; ExcCode_M = 5'd0; EXLClr = 1'b0; BD_M = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    WE = 1'b1; A2 = a; DIn = d;
    cyc();
    WE = 1'b0;
  endtask

  initial begin
    #5;
    peek(5'd15, PRID_V, "reset_prid");
    peek(5'd12, 32'd0, "reset_sr");
    reset = 1'b1;
    @(posedge clk); #1;

    // Write masks and read-only Cause.
    mtc0(5'd12, 32'hFFFF_FFFF);
    peek(5'd12, 32'h0000_FC03, "sr_mask");
    mtc0(5'd13, 32'h0000_1234);
    peek(5'd13, 32'h0000_0000, "cause_ro");
    mtc0(5'd12, 32'h0000_0000);

    // Synchronous exception entry.
    idle(); ExcCode_M = 5'd10; PC_M = 32'h3010; BD_M = 1'b0; #1;
    chk("ri_intreq", {31'd0, IntReq}, 32'd1);
    cyc();
    idle();
    peek(5'd14, 32'h0000_3010, "ri_epc");
    peek(5'd13, 32'h0000_0028, "ri_cause");
    peek(5'd12, 32'h0000_0002, "ri_exl");
    EXLClr = 1'b1; cyc(); idle();

    // Interrupt beats exception, delay slot entry.
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; ExcCode_M = 5'd12; PC_M = 32'h3024; BD_M = 1'b1; #1;
    chk("int_intreq", {31'd0, IntReq}, 32'd1);
    cyc();
    idle();
    peek(5'd13, 32'h8000_0400, "int_cause");
    peek(5'd14, 32'h0000_3020, "int_epc");

    // EXL masks everything until eret.
    ExcCode_M = 5'd4; #1;
    chk("exl_mask", {31'd0, IntReq}, 32'd0);
    idle(); EXLClr = 1'b1; #1;
    chk("eret_noreq", {31'd0, IntReq}, 32'd0);
    cyc(); idle(); #1;
    chk("post_eret_req", {31'd0, IntReq}, 32'd1);
    cyc();
    HWInt = 6'd0;
    EXLClr = 1'b1; cyc(); idle();

    // EPC bypass.
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3103; #1;
    chk("epc_bypass", EPC_out, 32'h0000_3100);
    cyc(); idle();
    peek(5'd14, 32'h0000_3100, "epc_after");

    // Asynchronous reset mid-run, then release with a line still high.
    mtc0(5'd14, 32'h0000_3000);
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b111111;
    #3; reset = 1'b0; m_reset();
    peek(5'd14, 32'd0, "rst_epc");
    peek(5'd12, 32'd0, "rst_sr");
    peek(5'd15, PRID_V, "rst_prid");
    reset = 1'b1; #1;
    chk("rst_noint", {31'd0, IntReq}, 32'd0);
    cyc();
    peek(5'd13, 32'h0000_FC00, "rst_ip");

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      A1 = 5'd10 + 5'($urandom_range(0, 6));
      WE = ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 3))
        0: A2 = 5'd12;
        1: A2 = 5'd13;
        2: A2 = 5'd14;
        default: A2 = 5'($urandom);
      endcase
      DIn = $urandom;
      PC_M = $urandom;
      BD_M = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) < 15) begin
        case ($urandom_range(0, 4))
          0: ExcCode_M = 5'd4;
          1: ExcCode_M = 5'd5;
          2: ExcCode_M = 5'd10;
          3: ExcCode_M = 5'd12;
          default: ExcCode_M = 5'($urandom);
        endcase
      end else begin
        ExcCode_M = 5'd0;
      end
      if ($urandom_range(0, 9) < 3) HWInt = 6'($urandom) & 6'($urandom);
      EXLClr = m_sr[1] && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2; reset = 1'b0; m_reset(); #1;
        chk("rnd_rst_dout", DOut, m_read(A1));
        reset = 1'b1;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
